xilinx_sdp_distram: RTL and testbench

Parametrised simple-dual-port distributed LUT RAM with one write port and one independent read port. Depth can exceed a single primitive: the block banks RAM64X1D/RAM32X1D slices and muxes the read data by the upper address bits. It adds an optional output register with read enable, a hardware clear sequencer after reset, and a sticky error flag for writes that are dropped during clear. It is used as a small register file or FIFO backing store in 7 Series designs.

---
 rtl/xilinx_sdp_distram.sv | 133 +++++++++++++
 tb/tb_xilinx_sdp_distram.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/xilinx_sdp_distram.sv
// Simple-dual-port distributed RAM, banked in 64-deep slices, with a post-reset clear sequencer.
// Latency: write commits at WCLK edge; read is 1 cycle (OUT_REG=1) or combinational (OUT_REG=0).
// Backpressure: none; BUSY marks clear ownership of the write port and dropped user writes set ERR.
`timescale 1ns/1ps
module xilinx_sdp_distram #(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 8,
    parameter int OUT_REG        = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  WCLK,
    input  logic                  RST,
    input  logic                  WE,
    input  logic [ADDR_WIDTH-1:0] WA,
    input  logic [DATA_WIDTH-1:0] D,
    input  logic                  RE,
    input  logic [ADDR_WIDTH-1:0] RA,
    output logic [DATA_WIDTH-1:0] RO,
    output logic                  BUSY,
    output logic                  ERR
);

    localparam int DEPTH   = 1 << ADDR_WIDTH;
    localparam int BANK_AW = (ADDR_WIDTH < 6) ? ADDR_WIDTH : 6;
    localparam int NBANK   = DEPTH >> BANK_AW;
    localparam int BSEL_W  = (NBANK > 1) ? (ADDR_WIDTH - BANK_AW) : 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
    logic                  err_q, err_d;
    logic                  busy;
    logic                  we_int;
    logic [ADDR_WIDTH-1:0] wa_int;
    logic [DATA_WIDTH-1:0] wd_int;
    logic [DATA_WIDTH-1:0] bank_rd [NBANK];
    logic [DATA_WIDTH-1:0] rd_word;

    // State register
    always_ff @(posedge WCLK) begin
        if (RST) begin
            state_q   <= RESET_STATE;
            clr_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            err_q     <= err_d;
        end
    end

    // Next-state: the counter walks every address once, leaving CLEAR after DEPTH-1
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (state_q == ST_CLEAR) begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (&clr_cnt_q) begin
                state_d = ST_IDLE;
            end
        end
    end

    // Output decode: the clear write overrides the user write port
    always_comb begin
        busy   = (state_q == ST_CLEAR);
        we_int = !RST && (busy || WE);
        wa_int = busy ? clr_cnt_q : WA;
        wd_int = busy ? '0 : D;
        err_d  = err_q || (WE && busy);
    end

    assign BUSY = busy;
    assign ERR  = err_q;

    for (genvar b = 0; b < NBANK; b++) begin : g_bank
        logic [DATA_WIDTH-1:0] ram_q [2**BANK_AW];
        logic                  bank_we;

        if (NBANK > 1) begin : g_sel
            assign bank_we = we_int && (wa_int[ADDR_WIDTH-1:BANK_AW] == BSEL_W'(b));
        end else begin : g_one
            assign bank_we = we_int;
        end

        always_ff @(posedge WCLK) begin
            if (bank_we) begin
                ram_q[wa_int[BANK_AW-1:0]] <= wd_int;
            end
        end

        assign bank_rd[b] = ram_q[RA[BANK_AW-1:0]];
    end

    if (NBANK > 1) begin : g_rmux
        assign rd_word = bank_rd[RA[ADDR_WIDTH-1:BANK_AW]];
    end else begin : g_rone
        assign rd_word = bank_rd[0];
    end

    if (OUT_REG != 0) begin : g_oreg
        logic [DATA_WIDTH-1:0] ro_q, ro_d;

        // Sampling the pre-edge array gives read-first behaviour on collisions
        always_comb begin
            ro_d = ro_q;
            if (RE) begin
                ro_d = rd_word;
            end
        end

        always_ff @(posedge WCLK) begin
            if (RST) begin
                ro_q <= '0;
            end else begin
                ro_q <= ro_d;
            end
        end

        assign RO = ro_q;
    end else begin : g_async
        logic unused_re;
        assign unused_re = RE;
        assign RO        = rd_word;
    end

endmodule

// File: tb/tb_xilinx_sdp_distram.sv
// Directed bench: registered 256x8 instance plus an asynchronous 32x1 instance.
// Read expectations are queued when RE is driven and compared one edge later.
`timescale 1ns/1ps
module tb_xilinx_sdp_distram;

    logic       clk = 1'b0;
    logic       rst, we, re;
    logic [7:0] wa, d, ra, ro;
    logic       busy, err;

    logic       a_rst, a_we, a_re;
    logic [4:0] a_wa, a_ra;
    logic [0:0] a_d, a_ro;
    logic       a_busy, a_err;

    int checks = 0;
    int errors = 0;

    logic [7:0] mdl [256];
    logic [7:0] exp_q [$];
    logic [7:0] last_exp;

    always #5 clk = ~clk;

    xilinx_sdp_distram #(
        .ADDR_WIDTH(8), .DATA_WIDTH(8), .OUT_REG(1), .CLEAR_ON_RESET(1)
    ) dut (
        .WCLK(clk), .RST(rst), .WE(we), .WA(wa), .D(d),
        .RE(re), .RA(ra), .RO(ro), .BUSY(busy), .ERR(err)
    );

    xilinx_sdp_distram #(
        .ADDR_WIDTH(5), .DATA_WIDTH(1), .OUT_REG(0), .CLEAR_ON_RESET(1)
    ) dut_a (
        .WCLK(clk), .RST(a_rst), .WE(a_we), .WA(a_wa), .D(a_d),
        .RE(a_re), .RA(a_ra), .RO(a_ro), .BUSY(a_busy), .ERR(a_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One user cycle on the registered instance; only used while idle
    task automatic cyc(input logic w, input logic [7:0] addr_w, input logic [7:0] data,
                       input logic r, input logic [7:0] addr_r, input string tag);
        we = w; wa = addr_w; d = data; re = r; ra = addr_r;
        if (r) last_exp = mdl[addr_r];
        exp_q.push_back(last_exp);
        if (w) mdl[addr_w] = data;
        tick();
        we = 1'b0; re = 1'b0;
        if (exp_q.size() == 0) chk("sb_empty", 64'd1, 64'd0);
        else                   chk(tag, ro, exp_q.pop_front());
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) tick();
        chk("rst_ro", ro, 8'h00);
        chk("rst_busy", busy, 1'b1);
        chk("rst_err", err, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 256; i++) mdl[i] = 8'h00;
        last_exp = 8'h00;
    endtask

    task automatic wait_clear(input int exp_n, input string tag);
        int n = 0;
        while (busy === 1'b1 && n < 1000) begin
            tick();
            n++;
        end
        chk(tag, n, exp_n);
    endtask

    task automatic sweep(input string tag);
        for (int a = 0; a < 256; a++) cyc(1'b0, 8'h00, 8'h00, 1'b1, 8'(a), tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; we = 1'b0; re = 1'b0; wa = '0; d = '0; ra = '0;
        a_rst = 1'b1; a_we = 1'b0; a_re = 1'b0; a_wa = '0; a_d = '0; a_ra = '0;
        last_exp = 8'h00;

        // Power-on clear
        do_reset(3);
        wait_clear(256, "busy_len");
        chk("err_after_clear", err, 1'b0);
        sweep("sweep_zero");

        // Bank-boundary writes, then reads and hold
        cyc(1'b1, 8'h3F, 8'hA5, 1'b0, 8'h00, "wr_3f_hold");
        cyc(1'b1, 8'h40, 8'h5A, 1'b0, 8'h00, "wr_40_hold");
        cyc(1'b0, 8'h00, 8'h00, 1'b1, 8'h3F, "rd_3f");
        cyc(1'b0, 8'h00, 8'h00, 1'b1, 8'h40, "rd_40");
        cyc(1'b0, 8'h00, 8'h00, 1'b0, 8'h3F, "re0_hold");

        // Read-first collision
        cyc(1'b1, 8'h10, 8'h11, 1'b0, 8'h00, "wr_10");
        cyc(1'b1, 8'h10, 8'h22, 1'b1, 8'h10, "collide_old");
        cyc(1'b0, 8'h00, 8'h00, 1'b1, 8'h10, "collide_new");
        cyc(1'b1, 8'h80, 8'h33, 1'b1, 8'h40, "indep_addr");

        // Write dropped at clear cycle 10
        do_reset(3);
        repeat (10) tick();
        chk("err_pre_drop", err, 1'b0);
        we = 1'b1; wa = 8'h05; d = 8'hFF;
        tick();
        we = 1'b0;
        chk("err_set", err, 1'b1);
        chk("busy_at_drop", busy, 1'b1);
        wait_clear(245, "busy_rest");
        chk("err_sticky", err, 1'b1);
        cyc(1'b0, 8'h00, 8'h00, 1'b1, 8'h05, "drop_rd_05");
        cyc(1'b0, 8'h00, 8'h00, 1'b1, 8'h3F, "cleared_3f");
        chk("err_still", err, 1'b1);
        do_reset(1);
        wait_clear(256, "busy_len2");

        // Reset in the middle of a clear
        cyc(1'b1, 8'h00, 8'h01, 1'b0, 8'h00, "wr_00");
        cyc(1'b1, 8'h80, 8'h80, 1'b0, 8'h00, "wr_80");
        cyc(1'b1, 8'hFF, 8'hFE, 1'b1, 8'h00, "wr_ff_rd_00");
        cyc(1'b0, 8'h00, 8'h00, 1'b1, 8'hFF, "rd_ff");
        do_reset(1);
        repeat (100) tick();
        chk("busy_c100", busy, 1'b1);
        rst = 1'b1;
        tick();
        chk("busy_midrst", busy, 1'b1);
        rst = 1'b0;
        wait_clear(256, "busy_restart");
        sweep("sweep_restart");

        // Asynchronous instance
        a_rst = 1'b0;
        begin
            int n = 0;
            while (a_busy === 1'b1 && n < 1000) begin
                tick();
                n++;
            end
            chk("a_busy_len", n, 32);
        end
        a_ra = 5'd31;
        #1;
        chk("a_cleared", a_ro, 1'b0);
        a_we = 1'b1; a_wa = 5'd31; a_d = 1'b1;
        #1;
        chk("a_pre_edge", a_ro, 1'b0);
        tick();
        a_we = 1'b0;
        chk("a_after_wr", a_ro, 1'b1);
        a_ra = 5'd30;
        for (int i = 0; i < 4; i++) begin
            a_re = ~a_re;
            tick();
            chk("a_re_ignored", a_ro, 1'b0);
        end
        a_re = 1'b0;
        a_ra = 5'd31;
        #1;
        chk("a_no_re", a_ro, 1'b1);
        chk("a_err", a_err, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
